// File: rtl/key_event_decoder_if.sv
// Signal bundle between one debounced key and its event decoder.
// The pulses are single-cycle strobes with no backpressure: a consumer samples them on the cycle they are high.
interface key_event_decoder_if;
  logic       key_in;
  logic       repeat_en;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] repeat_count;
  logic [1:0] state_dbg;

  modport master (
    output key_in, repeat_en,
    input  press_pulse, release_pulse, long_pulse, repeat_pulse,
    input  held, repeat_count, state_dbg
  );

  modport slave (
    input  key_in, repeat_en,
    output press_pulse, release_pulse, long_pulse, repeat_pulse,
    output held, repeat_count, state_dbg
  );
endinterface

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into press, release, long-press and auto-repeat pulses.
// All outputs are registered; the key level has one cycle of input latency through key_q.
module key_event_decoder #(
  parameter int unsigned CNT_WIDTH     = 24,
  parameter int unsigned LONG_CYCLES   = 12_500_000,
  parameter int unsigned REPEAT_CYCLES = 2_500_000
) (
  input logic                clock,
  input logic                reset,
  key_event_decoder_if.slave kif
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_TC   = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_TC = CNT_WIDTH'(REPEAT_CYCLES - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] counter;
  logic                 key_q;

  assign kif.state_dbg = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      counter           <= '0;
      key_q             <= 1'b0;
      kif.press_pulse   <= 1'b0;
      kif.release_pulse <= 1'b0;
      kif.long_pulse    <= 1'b0;
      kif.repeat_pulse  <= 1'b0;
      kif.held          <= 1'b0;
      kif.repeat_count  <= 8'd0;
    end else begin
      key_q             <= kif.key_in;
      kif.press_pulse   <= 1'b0;
      kif.release_pulse <= 1'b0;
      kif.long_pulse    <= 1'b0;
      kif.repeat_pulse  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_q) begin
            state            <= ST_PRESSED;
            kif.press_pulse  <= 1'b1;
            kif.held         <= 1'b1;
            counter          <= '0;
            kif.repeat_count <= 8'd0;
          end
        end
        ST_PRESSED: begin
          // Release is tested first so it wins over a coincident terminal count.
          if (!key_q) begin
            state             <= ST_IDLE;
            kif.release_pulse <= 1'b1;
            kif.held          <= 1'b0;
            counter           <= '0;
          end else if (counter == LONG_TC) begin
            state          <= ST_LONG;
            kif.long_pulse <= 1'b1;
            counter        <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        ST_LONG: begin
          if (!key_q) begin
            state             <= ST_IDLE;
            kif.release_pulse <= 1'b1;
            kif.held          <= 1'b0;
            counter           <= '0;
          end else if (!kif.repeat_en) begin
            counter <= '0;
          end else if (counter == REPEAT_TC) begin
            kif.repeat_pulse <= 1'b1;
            counter          <= '0;
            if (kif.repeat_count != 8'hFF) kif.repeat_count <= kif.repeat_count + 8'd1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          kif.held <= 1'b0;
          counter  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: expected events are queued with their cycle stamp
// when a hold is driven, and matched against every pulse the decoder produces.
module tb_key_event_decoder;
  localparam int CW = 4;
  localparam int LC = 8;
  localparam int RC = 4;
  localparam int W  = 20;

  localparam logic [3:0] EV_PRESS   = 4'b1000;
  localparam logic [3:0] EV_RELEASE = 4'b0100;
  localparam logic [3:0] EV_LONG    = 4'b0010;
  localparam logic [3:0] EV_REPEAT  = 4'b0001;
  localparam logic [1:0] ST_IDLE    = 2'd0;

  logic clock;
  logic reset;

  key_event_decoder_if kif ();

  key_event_decoder #(
    .CNT_WIDTH    (CW),
    .LONG_CYCLES  (LC),
    .REPEAT_CYCLES(RC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .kif  (kif)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int held_cnt = 0;
  logic [3:0]   mon_ev;
  logic [W-1:0] mon_got;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push(input int t, input logic [3:0] ev);
    exp_q.push_back({t[15:0], ev});
  endfunction

  // scoreboard: every pulse is stamped with the edge that produced it
  always @(negedge clock) begin
    mon_ev = {kif.press_pulse, kif.release_pulse, kif.long_pulse, kif.repeat_pulse};
    if (kif.held) held_cnt++;
    if (mon_ev != 4'd0) begin
      mon_got = {cyc[15:0], mon_ev};
      if (exp_q.size() == 0) check("spurious_event", 32'(mon_got), 32'd0);
      else check("event", 32'(mon_got), 32'(exp_q.pop_front()));
    end
  end

  // key_in raised after edge c gives press at c+2; n high cycles gives release n later
  task automatic drive_hold(input int n, input logic re);
    int c, p, rel, nrep, h0;
    @(negedge clock);
    kif.repeat_en = re;
    h0   = held_cnt;
    c    = cyc;
    p    = c + 2;
    rel  = p + n;
    nrep = 0;
    kif.key_in = 1'b1;
    push(p, EV_PRESS);
    if (n > LC) begin
      push(p + LC, EV_LONG);
      if (re) begin
        for (int t = p + LC + RC; t < rel; t += RC) begin
          push(t, EV_REPEAT);
          nrep++;
        end
      end
    end
    push(rel, EV_RELEASE);
    repeat (n) @(negedge clock);
    kif.key_in = 1'b0;
    repeat (6) @(negedge clock);
    check("held_cycles", 32'(held_cnt - h0), 32'(n));
    check("repeat_count", 32'(kif.repeat_count), 32'(nrep > 255 ? 255 : nrep));
    check("drain", 32'(exp_q.size()), 32'd0);
    check("state_idle", 32'(kif.state_dbg), 32'(ST_IDLE));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({kif.press_pulse, kif.release_pulse, kif.long_pulse, kif.repeat_pulse,
                   kif.held, kif.repeat_count, kif.state_dbg}), 32'd0);
  endtask

  initial begin
    int c, p, h0;
    reset = 1'b1;
    kif.key_in = 1'b0;
    kif.repeat_en = 1'b0;

    // 1: reset and idle
    repeat (3) @(negedge clock);
    check_all_zero("reset_outputs");
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check_all_zero("idle_outputs");

    // 3: long hold with repeats, then 2: short hold clears repeat_count
    drive_hold(30, 1'b1);
    drive_hold(3, 1'b0);
    // boundaries: tap, release on long terminal count, just past it, release on repeat terminal
    drive_hold(1, 1'b1);
    drive_hold(LC, 1'b1);
    drive_hold(LC + 1, 1'b1);
    drive_hold(LC + RC, 1'b1);
    drive_hold(20, 1'b0);

    // 4: repeat_en enabled late in the LONG state
    @(negedge clock);
    kif.repeat_en = 1'b0;
    h0 = held_cnt;
    c  = cyc;
    p  = c + 2;
    kif.key_in = 1'b1;
    push(p, EV_PRESS);
    push(p + 8, EV_LONG);
    push(p + 18, EV_REPEAT);
    push(p + 22, EV_REPEAT);
    push(p + 26, EV_RELEASE);
    while (cyc < p + 14) @(negedge clock);
    kif.repeat_en = 1'b1;
    while (cyc < p + 24) @(negedge clock);
    kif.key_in = 1'b0;
    repeat (6) @(negedge clock);
    check("late_en_held", 32'(held_cnt - h0), 32'd26);
    check("late_en_count", 32'(kif.repeat_count), 32'd2);
    check("late_en_drain", 32'(exp_q.size()), 32'd0);

    // 6: reset in the middle of a long hold with the key still down
    @(negedge clock);
    kif.repeat_en = 1'b1;
    c = cyc;
    p = c + 2;
    kif.key_in = 1'b1;
    push(p, EV_PRESS);
    push(p + 8, EV_LONG);
    while (cyc < p + 10) @(negedge clock);
    reset = 1'b1;
    #1;
    check_all_zero("midhold_reset");
    while (cyc < p + 12) @(negedge clock);
    check_all_zero("midhold_reset_held");
    reset = 1'b0;
    push(p + 14, EV_PRESS);
    while (cyc < p + 15) @(negedge clock);
    check("post_reset_held", 32'(kif.held), 32'd1);
    check("post_reset_count", 32'(kif.repeat_count), 32'd0);
    check("post_reset_drain", 32'(exp_q.size()), 32'd0);
    while (cyc < p + 16) @(negedge clock);
    kif.key_in = 1'b0;
    push(p + 18, EV_RELEASE);
    repeat (6) @(negedge clock);
    check("post_reset_release", 32'(exp_q.size()), 32'd0);

    // random holds
    for (int i = 0; i < 6; i++) begin
      drive_hold(int'($urandom_range(1, 30)), logic'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
